// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 register sequencer: state encoding,
// COM7 soft-reset write, end marker, colour-bar pattern writes and the RGB444/VGA table.
package ov7670_pkg;

    typedef enum logic [2:0] {
        SRST_ISSUE,
        SRST_WAIT,
        SETTLE,
        FETCH,
        ISSUE,
        WAIT_DONE,
        FINISHED
    } seq_state_t;

    localparam logic [7:0]  COM7_ADDR  = 8'h12;
    localparam logic [7:0]  COM7_SRST  = 8'h80;
    localparam logic [15:0] END_MARKER = 16'hFFFF;

    // 8-bar colour pattern: COM7-independent scaling registers 0x70/0x71
    function automatic logic [15:0] cbar_entry(input logic sel);
        return sel ? 16'h71B5 : 16'h704A;
    endfunction

    // RGB444 output, VGA framing; entries past the last one read as the end marker
    function automatic logic [15:0] table_entry(input int idx);
        logic [15:0] e;
        case (idx)
            0:       e = 16'h1204;
            1:       e = 16'h1100;
            2:       e = 16'h0C00;
            3:       e = 16'h3E00;
            4:       e = 16'h8C02;
            5:       e = 16'h0400;
            6:       e = 16'h1438;
            7:       e = 16'h4010;
            8:       e = 16'h3A04;
            9:       e = 16'h4FB3;
            10:      e = 16'h50B3;
            11:      e = 16'h5100;
            12:      e = 16'h523D;
            13:      e = 16'h53A7;
            14:      e = 16'h54E4;
            15:      e = 16'h589E;
            16:      e = 16'h3DC0;
            17:      e = 16'h1711;
            18:      e = 16'h1861;
            19:      e = 16'h32A4;
            20:      e = 16'h1903;
            21:      e = 16'h1A7B;
            22:      e = 16'h030A;
            default: e = END_MARKER;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ov7670_reg_sequencer.sv
// Walks the OV7670 register table over an SCCB write master after a COM7 soft reset.
// Define OV7670_COLORBAR_EN to append the two colour-bar test-pattern writes.
module ov7670_reg_sequencer
    import ov7670_pkg::*;
#(
    parameter int SETTLE_CYC  = 50000,
    parameter int TABLE_DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       resend,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    input  logic       cmd_done,
    output logic       config_finished,
    output logic       busy
);

    localparam int IDX_W = $clog2(TABLE_DEPTH + 1);
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    seq_state_t       state;
    logic [IDX_W-1:0] index;
    logic [CNT_W-1:0] settle_cnt;
    logic             pending;
    logic [15:0]      entry;
    logic             at_end;
    logic             do_restart;
`ifdef OV7670_COLORBAR_EN
    logic [1:0]       cbar_sel;
`else
`endif

    always_comb entry = table_entry(int'(index));
    assign at_end = (entry == END_MARKER);

    // A rerun either aborts an idle phase at once or waits for the in-flight write to finish
    always_comb begin
        do_restart = 1'b0;
        case (state)
            SETTLE, FETCH, FINISHED: do_restart = resend;
            SRST_WAIT, WAIT_DONE:    do_restart = cmd_done & (pending | resend);
            default:                 do_restart = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= SRST_ISSUE;
            index           <= '0;
            settle_cnt      <= '0;
            pending         <= 1'b0;
            config_finished <= 1'b0;
            busy            <= 1'b1;
            cmd_valid       <= 1'b0;
            cmd_addr        <= COM7_ADDR;
            cmd_data        <= COM7_SRST;
`ifdef OV7670_COLORBAR_EN
            cbar_sel        <= '0;
`else
`endif
        end else if (do_restart) begin
            state           <= SRST_ISSUE;
            index           <= '0;
            settle_cnt      <= '0;
            pending         <= 1'b0;
            config_finished <= 1'b0;
            busy            <= 1'b1;
            cmd_valid       <= 1'b1;
            cmd_addr        <= COM7_ADDR;
            cmd_data        <= COM7_SRST;
`ifdef OV7670_COLORBAR_EN
            cbar_sel        <= '0;
`else
`endif
        end else begin
            case (state)
                SRST_ISSUE: begin
                    if (resend) pending <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= SRST_WAIT;
                    end else begin
                        cmd_valid <= 1'b1;
                    end
                end
                SRST_WAIT: begin
                    if (resend) pending <= 1'b1;
                    if (cmd_done) begin
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        index <= '0;
                        state <= FETCH;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                FETCH: begin
                    if (index == IDX_W'(TABLE_DEPTH)) begin
                        busy            <= 1'b0;
                        config_finished <= 1'b1;
                        state           <= FINISHED;
                    end
`ifdef OV7670_COLORBAR_EN
                    else if (at_end && cbar_sel != 2'd2) begin
                        {cmd_addr, cmd_data} <= cbar_entry(cbar_sel[0]);
                        cmd_valid            <= 1'b1;
                        state                <= ISSUE;
                    end
`else
`endif
                    else if (at_end) begin
                        busy            <= 1'b0;
                        config_finished <= 1'b1;
                        state           <= FINISHED;
                    end else begin
                        {cmd_addr, cmd_data} <= entry;
                        cmd_valid            <= 1'b1;
                        state                <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (resend) pending <= 1'b1;
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (resend) pending <= 1'b1;
                    if (cmd_done) begin
                        state <= FETCH;
`ifdef OV7670_COLORBAR_EN
                        if (at_end) cbar_sel <= cbar_sel + 1'b1;
                        else        index    <= index + 1'b1;
`else
                        index <= index + 1'b1;
`endif
                    end
                end
                FINISHED: begin
                    busy            <= 1'b0;
                    config_finished <= 1'b1;
                end
                default: state <= SRST_ISSUE;
            endcase
        end
    end

endmodule

// File: doc/ov7670_reg_sequencer.md
OV7670_REG_SEQUENCER -- requirements
Module: ov7670_reg_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 50000, meaning idle cycles after COM7 soft reset (1 ms at 50 MHz).
REQ-002 SHALL have parameter TABLE_DEPTH, default 64, meaning maximum register-table entries scanned before a forced finish.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, clk50 domain.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 resend  in  1  debounced single-cycle request to rerun the full configuration.
REQ-007 cmd_valid  out  1  SCCB write request valid.
REQ-008 cmd_ready  in  1  SCCB master accepts request.
REQ-009 cmd_addr  out  8  camera register address.
REQ-010 cmd_data  out  8  camera register value.
REQ-011 cmd_done  in  1  single-cycle pulse: accepted write completed on the bus.
REQ-012 config_finished  out  1  high while the full table has been written and no rerun is pending.
REQ-013 busy  out  1  high in every state except FINISHED.

Function
REQ-014 States: SRST_ISSUE, SRST_WAIT, SETTLE, FETCH, ISSUE, WAIT_DONE, FINISHED.
REQ-015 SRST_ISSUE SHALL drive cmd_valid=1, cmd_addr=0x12, cmd_data=0x80; go to SRST_WAIT in the cycle after cmd_valid&cmd_ready.
REQ-016 SRST_WAIT SHALL go to SETTLE on cmd_done; SETTLE SHALL count exactly SETTLE_CYC cycles, then go to FETCH with index=0.
REQ-017 FETCH SHALL read table[index] (16 bits: addr[15:8], data[7:0]), register it onto cmd_addr/cmd_data and go to ISSUE; entry 0xFFFF or index==TABLE_DEPTH SHALL go to FINISHED instead.
REQ-018 ISSUE SHALL hold cmd_valid=1 with stable cmd_addr/cmd_data until cmd_ready; on handshake go to WAIT_DONE.
REQ-019 WAIT_DONE SHALL on cmd_done increment index and return to FETCH.
REQ-020 cmd_valid SHALL be 0 in all states except SRST_ISSUE and ISSUE; cmd_valid SHALL never drop without a handshake.
REQ-021 Per-entry overhead: FETCH 1 cycle, handshake accept-to-WAIT_DONE 1 cycle, cmd_done-to-FETCH 1 cycle.
REQ-022 cmd_done outside SRST_WAIT/WAIT_DONE SHALL be ignored.
REQ-023 resend in FINISHED SHALL go to SRST_ISSUE next cycle and clear config_finished that cycle.
REQ-024 resend in SETTLE or FETCH SHALL restart at SRST_ISSUE next cycle.
REQ-025 resend in ISSUE, SRST_ISSUE, WAIT_DONE or SRST_WAIT SHALL set a pending flag; the in-flight write SHALL complete (handshake plus cmd_done), then go to SRST_ISSUE and clear the flag.
REQ-026 Multiple resend pulses before restart SHALL collapse into one restart.
REQ-027 index SHALL be $clog2(TABLE_DEPTH+1) bits and never wrap.

Reset
REQ-028 rst SHALL force state=SRST_ISSUE, index=0, pending=0, config_finished=0, busy=1, cmd_addr=0x12, cmd_data=0x80; cmd_valid goes high the first cycle after rst deasserts.
REQ-029 rst mid-transaction SHALL abandon the transaction immediately; a late cmd_done SHALL be ignored per REQ-022.

Configuration
REQ-030 Macro OV7670_COLORBAR_EN: when defined, FETCH SHALL replace the 0xFFFF end marker with two extra writes, 0x70=0x4A and 0x71=0xB5 (8-bar color pattern), then finish; when undefined, the table ends at 0xFFFF with no pattern writes.

Structure
REQ-031 Package ov7670_pkg SHALL hold: state enum, COM7 address/soft-reset constants, end-marker 0xFFFF, colour-bar entries, and the RGB444/VGA register table as a constant function indexed by entry number.
REQ-032 Settle counter is inline; no sub-module; table is combinational logic read in FETCH.

Verification
REQ-033 Reset, SCCB model with ready=1 and done 10 cycles after accept, SETTLE_CYC=20 -> first write 0x12/0x80, no cmd_valid for 20 settle cycles, then table in order, config_finished=1 after last done.
REQ-034 cmd_ready held low 50 cycles in ISSUE -> cmd_valid, cmd_addr and cmd_data stable all 50 cycles; exactly one write per entry.
REQ-035 resend pulsed twice during WAIT_DONE of entry 5 -> entry 5 done completes, next write is 0x12/0x80, exactly one restart, entry 6 not issued.
REQ-036 resend during SETTLE at count 7 -> SRST_ISSUE next cycle, settle count restarts from 0.
REQ-037 Build with OV7670_COLORBAR_EN -> last two writes 0x70/0x4A and 0x71/0xB5 precede config_finished; without it, neither write appears.
REQ-038 rst asserted in WAIT_DONE with stray cmd_done one cycle later -> sequencer reissues 0x12/0x80, index stays 0.
